// File: rtl/or8_burst_acc.sv
// Burst accumulator: ORs up to BURST_LEN upstream bytes into one result.
// A result is held with a valid/ready handshake until downstream takes it.
module or8_burst_acc #(
   parameter int BURST_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       flush,
   output logic [7:0] out_data,
   output logic [3:0] out_count,
   output logic       out_partial,
   output logic       out_valid,
   input  logic       out_ready
);

   localparam int         DATA_W = 8;
   localparam logic [3:0] LEN    = 4'(BURST_LEN);

   typedef enum logic {
      ACC,
      HOLD
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] acc;
   logic [3:0]        cnt;

   logic              accept;
   logic [DATA_W-1:0] acc_next;
   logic [3:0]        cnt_next;

   // First word of a burst replaces the accumulator instead of ORing into it.
   function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] cur,
                                                    input logic [3:0]        n,
                                                    input logic [DATA_W-1:0] w);
      return (n == 4'd0) ? w : (cur | w);
   endfunction

   assign in_ready = (state == ACC) && rst_n;
   assign accept   = in_valid && in_ready;
   assign acc_next = merge_word(acc, cnt, in_data);
   assign cnt_next = cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ACC;
         acc         <= '0;
         cnt         <= '0;
         out_data    <= '0;
         out_count   <= '0;
         out_partial <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         unique case (state)
            ACC: begin
               if (accept) begin
                  // A flush arriving with a word closes the burst after merging it.
                  if ((cnt_next == LEN) || flush) begin
                     state       <= HOLD;
                     out_data    <= acc_next;
                     out_count   <= cnt_next;
                     out_partial <= (cnt_next < LEN);
                     out_valid   <= 1'b1;
                  end
                  acc <= acc_next;
                  cnt <= cnt_next;
               end else if (flush && (cnt != 4'd0)) begin
                  state       <= HOLD;
                  out_data    <= acc;
                  out_count   <= cnt;
                  out_partial <= 1'b1;
                  out_valid   <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACC;
                  acc       <= '0;
                  cnt       <= '0;
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_or8_burst_acc.sv
// Directed bench for or8_burst_acc: BURST_LEN=4 instance plus a BURST_LEN=1
// instance, with a result scoreboard per instance.
module tb_or8_burst_acc;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] a_in_data;
   logic       a_in_valid, a_in_ready, a_flush;
   logic [7:0] a_out_data;
   logic [3:0] a_out_count;
   logic       a_out_partial, a_out_valid, a_out_ready;

   logic [7:0] b_in_data;
   logic       b_in_valid, b_in_ready, b_flush;
   logic [7:0] b_out_data;
   logic [3:0] b_out_count;
   logic       b_out_partial, b_out_valid, b_out_ready;

   int tests = 0;
   int fails = 0;
   int n_a   = 0;
   int n_b   = 0;

   logic [12:0] q_a[$];
   logic [12:0] q_b[$];

   always #5 clk = ~clk;

   or8_burst_acc #(.BURST_LEN(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .flush(a_flush),
      .out_data(a_out_data), .out_count(a_out_count), .out_partial(a_out_partial),
      .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   or8_burst_acc #(.BURST_LEN(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .flush(b_flush),
      .out_data(b_out_data), .out_count(b_out_count), .out_partial(b_out_partial),
      .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [7:0] d, input logic f);
      a_in_valid = v;
      a_in_data  = d;
      a_flush    = f;
   endtask

   task automatic drive_b(input logic v, input logic [7:0] d);
      b_in_valid = v;
      b_in_data  = d;
   endtask

   // Feed a list of words back-to-back; flush rides on the last word if asked.
   task automatic burst_a(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3,
                          input int n, input logic flush_last);
      logic [7:0] w[4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < n; i++) begin
         drive_a(1'b1, w[i], flush_last && (i == n - 1));
         tick();
      end
      drive_a(1'b0, 8'h00, 1'b0);
   endtask

   // Scoreboard: compare each handshaken result, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         if (q_a.size() == 0) chk("a_unexpected_result", 32'(a_out_valid), 32'd0);
         else begin
            chk("a_result", 32'({a_out_data, a_out_count, a_out_partial}), 32'(q_a.pop_front()));
            n_a++;
         end
      end
      if (rst_n && b_out_valid && b_out_ready) begin
         if (q_b.size() == 0) chk("b_unexpected_result", 32'(b_out_valid), 32'd0);
         else begin
            chk("b_result", 32'({b_out_data, b_out_count, b_out_partial}), 32'(q_b.pop_front()));
            n_b++;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drive_a(1'b0, 8'h00, 1'b0);
      drive_b(1'b0, 8'h00);
      b_flush     = 1'b0;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_outputs", 32'({a_out_data, a_out_count, a_out_partial}), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", 32'(a_in_ready), 32'd1);

      // Full burst, ready downstream; in_data noise while idle must not matter
      drive_a(1'b0, 8'hFF, 1'b0);
      tick();
      q_a.push_back({8'h87, 4'd4, 1'b0});
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 8'h01 << i, 1'b0);
         tick();
      end
      chk("full_no_early_valid", 32'(a_out_valid), 32'd0);
      drive_a(1'b1, 8'h80, 1'b0);
      tick();
      drive_a(1'b0, 8'h00, 1'b0);
      chk("full_valid", 32'(a_out_valid), 32'd1);
      chk("full_result", 32'({a_out_data, a_out_count, a_out_partial}), 32'({8'h87, 4'd4, 1'b0}));
      chk("full_hold_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      chk("full_after_valid", 32'(a_out_valid), 32'd0);
      chk("full_after_in_ready", 32'(a_in_ready), 32'd1);

      // Backpressure: result held 5 cycles, words and flush ignored meanwhile
      a_out_ready = 1'b0;
      q_a.push_back({8'h87, 4'd4, 1'b0});
      burst_a(8'h01, 8'h02, 8'h04, 8'h80, 4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive_a(1'b1, 8'hEE, i[0]);
         chk("hold_valid", 32'(a_out_valid), 32'd1);
         chk("hold_data", 32'({a_out_data, a_out_count, a_out_partial}), 32'({8'h87, 4'd4, 1'b0}));
         chk("hold_in_ready", 32'(a_in_ready), 32'd0);
         tick();
      end
      drive_a(1'b0, 8'h00, 1'b0);
      a_out_ready = 1'b1;
      tick();
      chk("hold_release", 32'(a_out_valid), 32'd0);

      // Flush alone after two words, then flush on an empty burst
      q_a.push_back({8'h30, 4'd2, 1'b1});
      burst_a(8'h10, 8'h20, 8'h00, 8'h00, 2, 1'b0);
      drive_a(1'b0, 8'h00, 1'b1);
      tick();
      drive_a(1'b0, 8'h00, 1'b0);
      chk("flush_valid", 32'(a_out_valid), 32'd1);
      chk("flush_result", 32'({a_out_data, a_out_count, a_out_partial}), 32'({8'h30, 4'd2, 1'b1}));
      tick();
      drive_a(1'b0, 8'h00, 1'b1);
      tick();
      drive_a(1'b0, 8'h00, 1'b0);
      chk("empty_flush_valid", 32'(a_out_valid), 32'd0);
      tick();
      chk("empty_flush_valid2", 32'(a_out_valid), 32'd0);

      // Flush together with a word: partial at 3, full at 4
      q_a.push_back({8'h70, 4'd3, 1'b1});
      burst_a(8'h10, 8'h20, 8'h40, 8'h00, 3, 1'b1);
      chk("flushw3_result", 32'({a_out_data, a_out_count, a_out_partial}), 32'({8'h70, 4'd3, 1'b1}));
      tick();
      q_a.push_back({8'h0F, 4'd4, 1'b0});
      burst_a(8'h01, 8'h02, 8'h04, 8'h08, 4, 1'b1);
      chk("flushw4_result", 32'({a_out_data, a_out_count, a_out_partial}), 32'({8'h0F, 4'd4, 1'b0}));
      tick();

      // Reset mid-burst discards 0xFF
      burst_a(8'hFF, 8'h00, 8'h00, 8'h00, 2, 1'b0);
      rst_n = 1'b0;
      tick();
      chk("midrst_in_ready", 32'(a_in_ready), 32'd0);
      rst_n = 1'b1;
      q_a.push_back({8'h01, 4'd4, 1'b0});
      burst_a(8'h01, 8'h01, 8'h01, 8'h01, 4, 1'b0);
      chk("midrst_result", 32'({a_out_data, a_out_count, a_out_partial}), 32'({8'h01, 4'd4, 1'b0}));
      tick();

      // Reset while holding a result drops it unseen
      a_out_ready = 1'b0;
      burst_a(8'h11, 8'h22, 8'h44, 8'h88, 4, 1'b0);
      chk("holdrst_pre_valid", 32'(a_out_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("holdrst_valid", 32'(a_out_valid), 32'd0);
      chk("holdrst_outputs", 32'({a_out_data, a_out_count, a_out_partial}), 32'd0);
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      tick();
      chk("holdrst_after_valid", 32'(a_out_valid), 32'd0);

      // BURST_LEN=1: each word is a result, results two cycles apart
      q_b.push_back({8'hA5, 4'd1, 1'b0});
      q_b.push_back({8'h5A, 4'd1, 1'b0});
      drive_b(1'b1, 8'hA5);
      tick();
      drive_b(1'b1, 8'h5A);
      chk("b1_first", 32'({b_out_valid, b_out_data, b_out_count, b_out_partial}),
          32'({1'b1, 8'hA5, 4'd1, 1'b0}));
      chk("b1_hold_in_ready", 32'(b_in_ready), 32'd0);
      tick();
      chk("b1_gap_valid", 32'(b_out_valid), 32'd0);
      tick();
      drive_b(1'b0, 8'h00);
      chk("b1_second", 32'({b_out_valid, b_out_data, b_out_count, b_out_partial}),
          32'({1'b1, 8'h5A, 4'd1, 1'b0}));
      tick();
      tick();

      chk("a_results_seen", 32'(n_a), 32'd6);
      chk("b_results_seen", 32'(n_b), 32'd2);
      chk("a_queue_empty", 32'(q_a.size()), 32'd0);
      chk("b_queue_empty", 32'(q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
